// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: Q13 psum format limits, accumulator state
// encoding and the saturating narrow-back helper.
package cnn_pkg;

   localparam int PSUM_W = 16;
   localparam int Q_FRAC = 13;
   localparam int SUM_W  = PSUM_W + 2;

   localparam logic signed [PSUM_W-1:0] PSUM_MAX = 16'sh7FFF;
   localparam logic signed [PSUM_W-1:0] PSUM_MIN = 16'sh8000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Clamp a guard-bit-extended sum back into the psum range.
   function automatic logic signed [PSUM_W-1:0] sat_add(input logic signed [SUM_W-1:0] sum);
      logic signed [PSUM_W-1:0] res;
      if (sum[SUM_W-1] && !(&sum[SUM_W-2:PSUM_W-1])) begin
         res = PSUM_MIN;
      end else if (!sum[SUM_W-1] && (|sum[SUM_W-2:PSUM_W-1])) begin
         res = PSUM_MAX;
      end else begin
         res = sum[PSUM_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/psum_tile_buf.sv
// Tile-local partial-sum store: register array with synchronous write and
// combinational read. Contents are intentionally not reset.
module psum_tile_buf
   import cnn_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int WIDTH  = 16
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ofm_psum_accumulator.sv
// Accumulates column psums over input-channel passes in a tile buffer, then on
// the last pass adds bias, applies optional ReLU and streams the result out.
module ofm_psum_accumulator
   import cnn_pkg::*;
#(
   parameter int PSUM_WIDTH = 16,
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = 6,
   parameter int PASS_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W:0]       cfg_tile_len,
   input  logic [PASS_W-1:0]     cfg_num_pass,
   input  logic [PSUM_WIDTH-1:0] cfg_bias,
   input  logic                  cfg_relu_en,
   input  logic                  psum_valid,
   output logic                  psum_ready,
   input  logic [PSUM_WIDTH-1:0] psum_data,
   output logic                  ofm_valid,
   input  logic                  ofm_ready,
   output logic [PSUM_WIDTH-1:0] ofm_data,
   output logic                  busy,
   output logic                  done
);

   localparam int               EXT_W   = SUM_W - PSUM_WIDTH;
   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [PASS_W-1:0]       pass_q, pass_d;
   logic [PASS_W-1:0]       num_pass_q, num_pass_d;
   logic [ADDR_W:0]         tile_len_q, tile_len_d;
   logic [PSUM_WIDTH-1:0]   bias_q, bias_d;
   logic                    relu_q, relu_d;
   logic                    ofm_valid_q, ofm_valid_d;
   logic [PSUM_WIDTH-1:0]   ofm_data_q, ofm_data_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic                    last_pass_s, last_addr_s, rdy_s, beat_s, buf_we_s;
   logic [PSUM_WIDTH-1:0]   buf_rdata_s, buf_wdata_s, acc_s, sat3_s, result_s;
   logic signed [SUM_W-1:0] sum2_s, sum3_s;

   psum_tile_buf #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (PSUM_WIDTH)
   ) u_buf (
      .clk     (clk),
      .we_i    (buf_we_s),
      .addr_i  (addr_q),
      .wdata_i (buf_wdata_s),
      .rdata_o (buf_rdata_s)
   );

   // Beat acceptance; the last pass stalls only while a result is stuck downstream.
   always_comb begin
      last_pass_s = (pass_q == (num_pass_q - {{(PASS_W-1){1'b0}}, 1'b1}));
      last_addr_s = ({1'b0, addr_q} == (tile_len_q - {{ADDR_W{1'b0}}, 1'b1}));
      rdy_s       = (state_q == S_ACCUM) && (!last_pass_s || !ofm_valid_q || ofm_ready);
      beat_s      = psum_valid && rdy_s;
      buf_we_s    = beat_s && !last_pass_s;
   end

   // Datapath: a single saturation on the three-operand sum, ReLU after it.
   always_comb begin
      if (num_pass_q == {{(PASS_W-1){1'b0}}, 1'b1}) begin
         acc_s = {PSUM_WIDTH{1'b0}};
      end else begin
         acc_s = buf_rdata_s;
      end
      sum2_s = {{EXT_W{buf_rdata_s[PSUM_WIDTH-1]}}, buf_rdata_s}
             + {{EXT_W{psum_data[PSUM_WIDTH-1]}}, psum_data};
      sum3_s = {{EXT_W{acc_s[PSUM_WIDTH-1]}}, acc_s}
             + {{EXT_W{psum_data[PSUM_WIDTH-1]}}, psum_data}
             + {{EXT_W{bias_q[PSUM_WIDTH-1]}}, bias_q};
      sat3_s = sat_add(sum3_s);
      if (relu_q && sat3_s[PSUM_WIDTH-1]) begin
         result_s = {PSUM_WIDTH{1'b0}};
      end else begin
         result_s = sat3_s;
      end
      if (pass_q == {PASS_W{1'b0}}) begin
         buf_wdata_s = psum_data;
      end else begin
         buf_wdata_s = sat_add(sum2_s);
      end
   end

   // Next-state logic: FSM, config capture, counters and output register.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pass_d      = pass_q;
      num_pass_d  = num_pass_q;
      tile_len_d  = tile_len_q;
      bias_d      = bias_q;
      relu_d      = relu_q;
      ofm_data_d  = ofm_data_q;
      ofm_valid_d = ofm_valid_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACCUM;
               addr_d  = {ADDR_W{1'b0}};
               pass_d  = {PASS_W{1'b0}};
               bias_d  = cfg_bias;
               relu_d  = cfg_relu_en;
               if (cfg_tile_len == {(ADDR_W+1){1'b0}}) begin
                  tile_len_d = {{ADDR_W{1'b0}}, 1'b1};
               end else if (cfg_tile_len > DEPTH_L) begin
                  tile_len_d = DEPTH_L;
               end else begin
                  tile_len_d = cfg_tile_len;
               end
               if (cfg_num_pass == {PASS_W{1'b0}}) begin
                  num_pass_d = {{(PASS_W-1){1'b0}}, 1'b1};
               end else begin
                  num_pass_d = cfg_num_pass;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCUM: begin
            if (beat_s && last_pass_s && last_addr_s) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_ACCUM;
            end
         end
         S_DRAIN: begin
            if (!ofm_valid_q || ofm_ready) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (beat_s) begin
         if (last_addr_s) begin
            addr_d = {ADDR_W{1'b0}};
            pass_d = pass_q + {{(PASS_W-1){1'b0}}, 1'b1};
         end else begin
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
         end
      end else begin
         addr_d = addr_d;
      end

      if (beat_s && last_pass_s) begin
         ofm_valid_d = 1'b1;
         ofm_data_d  = result_s;
      end else if (ofm_ready) begin
         ofm_valid_d = 1'b0;
      end else begin
         ofm_valid_d = ofm_valid_q;
      end

      busy_d = (state_d == S_ACCUM) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
   end

   // State register; buffer contents deliberately excluded from reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= {ADDR_W{1'b0}};
         pass_q      <= {PASS_W{1'b0}};
         num_pass_q  <= {{(PASS_W-1){1'b0}}, 1'b1};
         tile_len_q  <= {{ADDR_W{1'b0}}, 1'b1};
         bias_q      <= {PSUM_WIDTH{1'b0}};
         relu_q      <= 1'b0;
         ofm_valid_q <= 1'b0;
         ofm_data_q  <= {PSUM_WIDTH{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pass_q      <= pass_d;
         num_pass_q  <= num_pass_d;
         tile_len_q  <= tile_len_d;
         bias_q      <= bias_d;
         relu_q      <= relu_d;
         ofm_valid_q <= ofm_valid_d;
         ofm_data_q  <= ofm_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign psum_ready = rdy_s;
   assign ofm_valid  = ofm_valid_q;
   assign ofm_data   = ofm_data_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_ofm_psum_accumulator.sv
// Directed bench for ofm_psum_accumulator: a pass-level arithmetic model feeds an
// expected-output queue that a negedge monitor checks on every ofm handshake.
module tb_ofm_psum_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [6:0]  cfg_tile_len = 7'd0;
   logic [7:0]  cfg_num_pass = 8'd0;
   logic [15:0] cfg_bias = 16'd0;
   logic        cfg_relu_en = 1'b0;
   logic        psum_valid = 1'b0;
   logic [15:0] psum_data = 16'd0;
   logic        ofm_ready = 1'b1;
   logic        psum_ready, ofm_valid, busy, done;
   logic [15:0] ofm_data;

   ofm_psum_accumulator dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cfg_tile_len (cfg_tile_len),
      .cfg_num_pass (cfg_num_pass),
      .cfg_bias     (cfg_bias),
      .cfg_relu_en  (cfg_relu_en),
      .psum_valid   (psum_valid),
      .psum_ready   (psum_ready),
      .psum_data    (psum_data),
      .ofm_valid    (ofm_valid),
      .ofm_ready    (ofm_ready),
      .ofm_data     (ofm_data),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   int          out_cnt = 0;
   int          done_cnt = 0;
   int          beats_acc = 0;
   int          early_lim = 0;
   logic        hold_v = 1'b0;
   logic [15:0] hold_d = 16'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      else if (v < -32768) return -32768;
      else return v;
   endfunction

   // Output monitor: handshake data, stall stability and early-output checks.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_v) begin
            chk("hold_valid", {31'd0, ofm_valid}, 32'd1);
            chk("hold_data", {16'd0, ofm_data}, {16'd0, hold_d});
         end
         if (ofm_valid && beats_acc <= early_lim) begin
            n_vec++;
            n_err++;
            $display("FAIL early_ofm: ofm_valid after %0d beats, allowed only after %0d", beats_acc, early_lim);
         end
         if (ofm_valid && !ofm_ready)
            chk("stall_psum_ready", {31'd0, psum_ready}, 32'd0);
         if (ofm_valid && ofm_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL extra_ofm: got %h, required no beat", ofm_data);
            end else begin
               chk("ofm_data", {16'd0, ofm_data}, {16'd0, exp_q.pop_front()});
            end
            out_cnt <= out_cnt + 1;
         end
         if (done) done_cnt <= done_cnt + 1;
         hold_v <= ofm_valid && !ofm_ready;
         hold_d <= ofm_data;
      end else begin
         hold_v <= 1'b0;
      end
   end

   task automatic send_beats(input logic [15:0] ps[$], input int n);
      bit ok;
      for (int i = 0; i < n; i++) begin
         psum_valid = 1'b1;
         psum_data  = ps[i];
         ok = 1'b0;
         for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (psum_ready) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout: beat %0d not accepted, required acceptance within 200 cycles", i);
            psum_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         beats_acc++;
      end
      psum_valid = 1'b0;
   endtask

   task automatic do_start(input int len, input int np, input logic [15:0] bias, input bit relu);
      @(posedge clk);
      #1;
      start        = 1'b1;
      cfg_tile_len = len[6:0];
      cfg_num_pass = np[7:0];
      cfg_bias     = bias;
      cfg_relu_en  = relu;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_tile(input int len, input int np, input logic [15:0] bias, input bit relu,
                           input logic [15:0] ps[$], input logic [15:0] lit[$],
                           input int mid_start, input bit bp);
      int          len_c, np_c, x, r, base_out, base_done;
      int          acc[64];
      logic [15:0] res[$];
      logic [15:0] rv;
      len_c = (len == 0) ? 1 : ((len > 64) ? 64 : len);
      np_c  = (np == 0) ? 1 : np;
      for (int p = 0; p < np_c; p++) begin
         for (int a = 0; a < len_c; a++) begin
            x = int'($signed(ps[p*len_c + a]));
            if (p == np_c - 1) begin
               r = sat16(((np_c == 1) ? 0 : acc[a]) + x + int'($signed(bias)));
               if (relu && r < 0) r = 0;
               rv = r[15:0];
               res.push_back(rv);
            end else if (p == 0) begin
               acc[a] = x;
            end else begin
               acc[a] = sat16(acc[a] + x);
            end
         end
      end
      foreach (lit[i]) chk("model_pin", {16'd0, res[i]}, {16'd0, lit[i]});
      foreach (res[i]) exp_q.push_back(res[i]);
      beats_acc = 0;
      early_lim = (np_c - 1) * len_c;
      base_out  = out_cnt;
      base_done = done_cnt;
      if (bp) ofm_ready = 1'b0;
      do_start(len, np, bias, relu);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      fork
         send_beats(ps, np_c * len_c);
         if (mid_start > 0) begin
            repeat (mid_start) @(posedge clk);
            #1;
            start        = 1'b1;
            cfg_tile_len = 7'd3;
            cfg_num_pass = 8'd5;
            cfg_bias     = 16'h1234;
            cfg_relu_en  = ~relu;
            @(posedge clk);
            #1;
            start = 1'b0;
         end
         if (bp) begin
            for (int k = 0; k < 200 && !ofm_valid; k++) @(negedge clk);
            repeat (5) @(posedge clk);
            #1;
            ofm_ready = 1'b1;
         end
      join
      for (int k = 0; k < 300 && done_cnt == base_done; k++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk("done_pulses", done_cnt - base_done, 32'd1);
      chk("ofm_count", out_cnt - base_out, len_c);
      chk("exp_drained", exp_q.size(), 32'd0);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [15:0] big[$];
      int          base_done;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_psum_ready", {31'd0, psum_ready}, 32'd0);
      chk("rst_ofm_valid", {31'd0, ofm_valid}, 32'd0);
      chk("rst_ofm_data", {16'd0, ofm_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single pass, ReLU and positive saturation.
      run_tile(4, 1, 16'h2000, 1'b1, '{16'h1000, 16'hE000, 16'h0000, 16'h7000},
               '{16'h3000, 16'h0000, 16'h2000, 16'h7FFF}, 0, 1'b0);
      // Three-pass accumulation.
      run_tile(2, 3, 16'h0000, 1'b0, '{16'h0100, 16'hFF00, 16'h0100, 16'hFF00, 16'h0100, 16'hFF00},
               '{16'h0300, 16'hFD00}, 0, 1'b0);
      // Negative saturation, without then with ReLU.
      run_tile(1, 2, 16'h8000, 1'b0, '{16'h8000, 16'hC000}, '{16'h8000}, 0, 1'b0);
      run_tile(1, 2, 16'h8000, 1'b1, '{16'h8000, 16'hC000}, '{16'h0000}, 0, 1'b0);
      // Backpressure on the first last-pass result.
      run_tile(4, 2, 16'h0000, 1'b0, '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                       16'h0010, 16'h0020, 16'h0030, 16'h0040},
               '{16'h0011, 16'h0022, 16'h0033, 16'h0044}, 0, 1'b1);

      // Reset during pass 1 of 3.
      exp_q.delete();
      beats_acc = 0;
      early_lim = 1000000;
      do_start(2, 3, 16'h0000, 1'b0);
      send_beats('{16'h0100, 16'h0200, 16'h0300}, 3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ofm_valid", {31'd0, ofm_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_psum_ready", {31'd0, psum_ready}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base_done = done_cnt;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_no_done", done_cnt - base_done, 32'd0);
      run_tile(3, 1, 16'h0010, 1'b0, '{16'h0001, 16'hFFFF, 16'h0100},
               '{16'h0011, 16'h000F, 16'h0110}, 0, 1'b0);

      // Start while busy is ignored.
      run_tile(2, 2, 16'h0100, 1'b0, '{16'h0010, 16'h0020, 16'h0030, 16'h0040},
               '{16'h0140, 16'h0160}, 1, 1'b0);
      // Clamps: zero length and zero passes act as one; oversize length clamps to 64.
      run_tile(0, 0, 16'h0005, 1'b0, '{16'h0123}, '{16'h0128}, 0, 1'b0);
      for (int i = 0; i < 64; i++) big.push_back(16'(i * 16));
      run_tile(127, 1, 16'h0000, 1'b0, big, '{16'h0000, 16'h0010}, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ofm_psum_accumulator.md
Name: ofm_psum_accumulator

Overview:
- Sits directly downstream of the PE array column output and consumes the final psum_out of a column, one output pixel per accepted beat.
- Accumulates partial sums across multiple input-channel passes in a local tile buffer, all in Q13 fixed point.
- On the last pass it adds the bias, applies optional ReLU, saturates, and streams the result to the OFM write path over a valid/ready handshake.

Parameters:
- PSUM_WIDTH, 16, signed psum/ofm width, Q-format with Q_FRAC fractional bits
- Q_FRAC, 13, fractional bits; the bias uses the same format
- DEPTH, 64, maximum output pixels per tile (buffer entries)
- ADDR_W, 6, log2(DEPTH)
- PASS_W, 8, width of the pass counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  one-cycle pulse; latches cfg_* and begins a tile (honoured only in IDLE)
- cfg_tile_len  in  ADDR_W+1  pixels per pass; 0 is treated as 1, values above DEPTH are clamped to DEPTH
- cfg_num_pass  in  PASS_W  input-channel passes; 0 is treated as 1
- cfg_bias  in  PSUM_WIDTH  signed Q13 bias
- cfg_relu_en  in  1  when 1, negative results are forced to 0
- psum_valid  in  1  upstream data valid
- psum_ready  out  1  block can accept psum_data
- psum_data  in  PSUM_WIDTH  signed partial sum from the PE column
- ofm_valid  out  1  ofm_data valid
- ofm_ready  in  1  downstream accepts
- ofm_data  out  PSUM_WIDTH  final activation
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the tile is fully drained

Behaviour:
- Reset values: psum_ready=0, ofm_valid=0, ofm_data=0, busy=0, done=0; state=IDLE; addr=0, pass=0. Buffer contents are not reset and are don't-care. Asserting reset mid-operation aborts the tile immediately, with no done pulse and any pending output lost.
- States:
  - IDLE: on start, latch cfg (clamped), addr=0, pass=0, busy=1, go to ACCUM. Otherwise remain.
  - ACCUM: accept beats (psum_valid & psum_ready).
  - DRAIN: wait for ofm_valid to clear.
  - DONE: one cycle; done=1, busy=0, then IDLE.
- start outside IDLE is ignored. Config is sampled only at accepted start.
- Beat handling, with last = (pass == num_pass-1):
  - pass==0 and not last: buf[addr] <= psum_data.
  - 0<pass and not last: buf[addr] <= sat(buf[addr] + psum_data).
  - last: the output register loads relu(sat(acc + psum_data + bias)), where acc = 0 if num_pass==1, else buf[addr]. ofm_valid <= 1. buf is not written.
- Arithmetic:
  - The three-operand sum is computed at PSUM_WIDTH+2 bits and saturated once to [0x8000, 0x7FFF].
  - The two-operand add is also saturated.
  - ReLU is applied after saturation.
- Buffer read is combinational (register array); one beat per cycle max.
- psum_ready:
  - 1 in ACCUM during non-last passes.
  - In the last pass, (!ofm_valid | ofm_ready), i.e. a single-stage output register with no bubble.
  - 0 in IDLE, DRAIN and DONE.
- Output handshake:
  - ofm_valid clears on ofm_ready unless a new result loads the same cycle.
  - ofm_data is held stable while ofm_valid & !ofm_ready.
- Counters:
  - addr increments per accepted beat; at tile_len-1 it wraps to 0 and pass increments.
  - Acceptance of the last beat of the last pass moves ACCUM→DRAIN.
- DRAIN→DONE when ofm_valid==0 or the final ofm handshake occurs that cycle.
- Latency: accepted last-pass beat → ofm_valid the next cycle.

Decomposition:
- Shared package (cnn_pkg), holding:
  - Q_FRAC, PSUM_MAX=0x7FFF and PSUM_MIN=0x8000 for the default width
  - the state enum {IDLE, ACCUM, DRAIN, DONE}
  - a sat_add function (N-bit wide input → PSUM_WIDTH saturated)
- One sub-module: psum_tile_buf (DEPTH×PSUM_WIDTH register array, sync write, async read, no reset).

Test Plan:
- Single pass with ReLU and saturation.
  - Stimulus: num_pass=1, tile_len=4, bias=0x2000, relu=1; psums 0x1000, 0xE000, 0x0000, 0x7000.
  - Required: ofm 0x3000, 0x0000, 0x2000, 0x7FFF, then done after the 4th handshake.
- Multi-pass accumulation.
  - Stimulus: num_pass=3, tile_len=2, bias=0, relu=0; each pass {0x0100, 0xFF00}.
  - Required: ofm 0x0300, 0xFD00; exactly 2 ofm beats, none during passes 0–1.
- Negative saturation.
  - Stimulus: num_pass=2, tile_len=1, bias=0x8000, relu=0; psums 0x8000, 0xC000.
  - Required: ofm 0x8000; with relu=1, ofm 0x0000.
- Backpressure.
  - Stimulus: last pass, ofm_ready held 0 for 5 cycles with psum_valid=1.
  - Required: psum_ready=0 while ofm_valid is stalled, ofm_data stable, no lost or duplicated beats; output count equals tile_len.
- Reset mid-tile.
  - Stimulus: rst_n low during pass 1 of 3.
  - Required: ofm_valid=0, busy=0, psum_ready=0, no done. A subsequent start with num_pass=1 produces correct outputs.
- Start while busy, plus clamps.
  - Stimulus: start pulse during ACCUM with different cfg.
  - Required: ignored, original results unchanged.
  - Stimulus: tile_len=0, num_pass=0 from IDLE.
  - Required: one beat accepted, one ofm, done.
